dmem_subword_ctrl: RTL and testbench



---
 rtl/dmem_subword_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dmem_subword_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_subword_ctrl.sv
// ============================================================================
// Module   : dmem_subword_ctrl
// Brief    : Word-organised data RAM with MIPS sub-word loads/stores, fixed
//            access latency and alignment/range/mode error responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_subword_ctrl #(
    parameter int WORDS   = 2048,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          c_ADDR_W   = $clog2(WORDS);
    localparam logic [31:0] c_WORDS32  = 32'(WORDS);
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [2:0]          r_mode;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic [31:0]         r_rdata;
    logic                r_resp_err;
    logic [31:0]         r_mem [WORDS] = '{default: '0};

    logic                w_accept;
    logic                w_access;
    logic                w_wr;
    logic                w_req_err;
    logic [c_ADDR_W-1:0] w_idx;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;
    logic [3:0]          w_be;
    logic [31:0]         w_lanes;

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_wr     = w_access && r_we && !r_err;
    assign w_idx    = r_addr[c_ADDR_W+1:2];

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = S_WAIT;
            end
            S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_err = 1'b0;
        case (req_mode)
            3'b000, 3'b100: w_req_err = 1'b0;
            3'b001, 3'b101: w_req_err = req_addr[0];
            3'b010:         w_req_err = |req_addr[1:0];
            default:        w_req_err = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= c_WORDS32) w_req_err = 1'b1;
    end

    // Rejected requests still pass through one WAIT cycle (counter forced to
    // zero) so their response lands one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_mode     <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
            r_resp_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_mode  <= req_mode;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= w_req_err;
                r_cnt   <= w_req_err ? 4'd0 : c_CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_rdata    <= (r_err || r_we) ? 32'd0 : w_load;
                r_resp_err <= r_err;
            end
        end
    end

    always_comb begin
        w_word = r_mem[w_idx];
        w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
        case (r_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        // mode[2] selects zero extension for the sub-word loads
        case (r_mode[1:0])
            2'b00:   w_load = {{24{w_byte[7] & ~r_mode[2]}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & ~r_mode[2]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        case (r_mode[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_lanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_subword_ctrl.sv
// ============================================================================
// Module   : tb_dmem_subword_ctrl
// Brief    : Self-checking bench for dmem_subword_ctrl; two instances
//            (LATENCY 1 and 3) checked against a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_subword_ctrl;

    localparam int TW = 256;

    logic        clk = 1'b0;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_mode   [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0] mref [2][TW*4];

    always #5 clk = ~clk;

    dmem_subword_ctrl #(.WORDS(TW), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_mode(req_mode[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0])
    );

    dmem_subword_ctrl #(.WORDS(TW), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_mode(req_mode[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory as a flat little-endian byte array; access size from the mode code.
    function automatic void model(input int i, input bit we, input logic [2:0] mode,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output bit err, output logic [31:0] rd);
        int sz;
        logic [31:0] v;
        case (mode)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        err = (sz == 0) || (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'd0)
              || ((addr >> 2) >= 32'(TW));
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < sz; b++) mref[i][int'(addr) + b] = wd[8*b +: 8];
            end else begin
                v = 32'd0;
                for (int b = 0; b < sz; b++) v = v | (32'(mref[i][int'(addr) + b]) << (8*b));
                if (!mode[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8*sz)) - 32'h1);
                rd = v;
            end
        end
    endfunction

    task automatic run(input int i, input bit we, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        bit          e_err;
        logic [31:0] e_rd;
        int          elat, pulses, low, k;
        bit          done;
        string       id;
        id = $sformatf("d%0d_%s_m%0d_a%08h", lat_of(i), we ? "st" : "ld", mode, addr);
        k = 0;
        while (req_ready[i] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_mode[i]  = mode;
        req_addr[i]  = addr;
        req_wdata[i] = wd;
        model(i, we, mode, addr, wd, e_err, e_rd);
        elat = e_err ? 1 : lat_of(i);
        @(posedge clk);
        pulses = 0;
        low    = 0;
        done   = 1'b0;
        for (k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (resp_valid[i] === 1'b1) begin
                pulses++;
                chk({id, "_latency"}, 32'(k), 32'(elat));
                chk({id, "_rdata"}, resp_rdata[i], e_rd);
                chk({id, "_err"}, 32'(resp_err[i]), 32'(e_err));
            end
            if (req_ready[i] === 1'b1) begin
                done = 1'b1;
            end else begin
                low++;
                // busy-time inputs must be ignored
                req_valid[i] = hold ? 1'b1 : 1'($urandom_range(0, 1));
                req_we[i]    = 1'($urandom_range(0, 1));
                req_mode[i]  = 3'($urandom_range(0, 7));
                req_addr[i]  = $urandom;
                req_wdata[i] = $urandom;
            end
        end
        chk({id, "_pulses"}, 32'(pulses), 32'd1);
        chk({id, "_ready_low"}, 32'(low), 32'(elat + 1));
        if (!hold) req_valid[i] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  mode;
        logic [31:0] addr;
        int          r;
        bit          h;

        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < TW*4; a++) mref[i][a] = 8'd0;
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_mode[i]  = 3'd0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_reset_ready", lat_of(i)), 32'(req_ready[i]), 32'd1);
            chk($sformatf("d%0d_reset_valid", lat_of(i)), 32'(resp_valid[i]), 32'd0);
            chk($sformatf("d%0d_reset_rdata", lat_of(i)), resp_rdata[i], 32'd0);
            chk($sformatf("d%0d_reset_err", lat_of(i)), 32'(resp_err[i]), 32'd0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        for (int i = 0; i < 2; i++) begin
            h = (i == 1);
            for (int w = 0; w < 32; w++) run(i, 1'b1, 3'b010, 32'(w * 4), $urandom, h);
            run(i, 1'b1, 3'b010, 32'h20, 32'h12345678, h);
            run(i, 1'b0, 3'b010, 32'h20, 32'h0, h);
            run(i, 1'b1, 3'b010, 32'h40, 32'h11223344, h);
            run(i, 1'b1, 3'b000, 32'h41, 32'h000000AA, h);
            run(i, 1'b1, 3'b001, 32'h42, 32'h0000BEEF, h);
            run(i, 1'b0, 3'b010, 32'h40, 32'h0, h);
            run(i, 1'b0, 3'b000, 32'h41, 32'h0, h);
            run(i, 1'b0, 3'b100, 32'h41, 32'h0, h);
            run(i, 1'b0, 3'b001, 32'h42, 32'h0, h);
            run(i, 1'b0, 3'b101, 32'h42, 32'h0, h);
            run(i, 1'b0, 3'b010, 32'h22, 32'h0, h);
            run(i, 1'b1, 3'b001, 32'h45, 32'h0000FFFF, h);
            run(i, 1'b0, 3'b010, 32'h44, 32'h0, h);
            run(i, 1'b0, 3'b011, 32'h40, 32'h0, h);
            run(i, 1'b0, 3'b010, 32'(TW * 4), 32'h0, h);
            run(i, 1'b1, 3'b010, 32'((TW - 1) * 4), 32'hCAFEF00D, h);
            run(i, 1'b0, 3'b010, 32'((TW - 1) * 4), 32'h0, h);

            for (int n = 0; n < 60; n++) begin
                r = int'($urandom_range(0, 99));
                case ($urandom_range(0, 4))
                    0: mode = 3'd0;
                    1: mode = 3'd1;
                    2: mode = 3'd2;
                    3: mode = 3'd4;
                    default: mode = 3'd5;
                endcase
                if (r < 8) mode = (r < 3) ? 3'd3 : ((r < 6) ? 3'd6 : 3'd7);
                addr = 32'($urandom_range(0, 127));
                if (r >= 8 && r < 14) addr = 32'(TW * 4) + 32'($urandom_range(0, 4095));
                if (r >= 14 && r < 18) addr = 32'((TW - 1) * 4) + 32'($urandom_range(0, 3));
                run(i, 1'($urandom_range(0, 1)), mode, addr, $urandom, h);
            end
            req_valid[i] = 1'b0;
        end

        // Reset in the middle of a pending store on the LATENCY=3 instance.
        run(1, 1'b1, 3'b010, 32'h10, 32'h0, 1'b0);
        run(1, 1'b0, 3'b010, 32'((TW - 1) * 4), 32'h0, 1'b0);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_mode[1]  = 3'b010;
        req_addr[1]  = 32'h10;
        req_wdata[1] = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst_n[1]     = 1'b0;
        #1;
        chk("d3_midwait_reset_ready", 32'(req_ready[1]), 32'd1);
        chk("d3_midwait_reset_valid", 32'(resp_valid[1]), 32'd0);
        chk("d3_midwait_reset_rdata", resp_rdata[1], 32'd0);
        chk("d3_midwait_reset_err", 32'(resp_err[1]), 32'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        r = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid[1] === 1'b1) r++;
        end
        chk("d3_no_resp_after_reset", 32'(r), 32'd0);
        run(1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);

        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
